alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle controller that sequences the register file, ALU operand mux and ALU of the reduced RISC-V datapath for one command at a time. It accepts a decoded command over a valid/ready handshake and drives the regfile read and write addresses, the write enable, the operand-mux select and the ALU control. It samples the ALU equality flag and returns a completion response with the branch result. It sits between the decode/test driver and the regfile+mux+ALU datapath.

Parameters:
DATA_WIDTH, 32, width of the immediate and datapath words
ADDR_WIDTH, 5, register address width
CNT_WIDTH, 16, width of the retired-command counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_op  in  2  00 ADD, 01 ADDI, 10 BNE, 11 SUB
cmd_rs1  in  ADDR_WIDTH  source register 1
cmd_rs2  in  ADDR_WIDTH  source register 2
cmd_rd  in  ADDR_WIDTH  destination register
cmd_imm  in  DATA_WIDTH  immediate value
rs1_addr  out  ADDR_WIDTH  regfile read address 1
rs2_addr  out  ADDR_WIDTH  regfile read address 2
rd_addr  out  ADDR_WIDTH  regfile write address
reg_we  out  1  regfile write enable
alu_src  out  1  operand-mux select, 1 = immediate
alu_ctrl  out  3  ALU control, 000 ADD, 001 SUB
imm_op  out  DATA_WIDTH  immediate to operand mux
alu_eq  in  1  ALU equal/zero flag
rsp_valid  out  1  command complete
rsp_ready  in  1  response consumed
rsp_taken  out  1  BNE taken (valid with rsp_valid; 0 for non-BNE)
retired  out  CNT_WIDTH  count of completed commands

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 (cmd_ready=0 while in reset). Captured command regs and retired are cleared. Reset mid-command abandons the command, and no reg_we is issued afterwards.
- States:
  - IDLE: cmd_ready=1.
  - READ: addresses and mux select are driven; regfile reads settle.
  - EXEC: ALU evaluates; alu_eq is registered at the end of the cycle.
  - WB: reg_we pulses for one cycle.
  - RSP: rsp_valid=1.
- Transitions:
  - IDLE->READ on cmd_valid.
  - READ->EXEC->WB->RSP unconditionally.
  - RSP->IDLE on rsp_ready.
  - RSP->READ when rsp_ready and cmd_valid are both high (back-to-back).
- cmd_ready = (state==IDLE) or (state==RSP and rsp_ready). The command is captured on the accept edge.
- Latency: accept at edge T gives READ in cycle T+1, EXEC T+2, WB T+3, RSP T+4. Throughput is one command per 4 cycles under back-to-back operation.
- rs1_addr, rs2_addr, rd_addr, imm_op, alu_src and alu_ctrl are taken from the captured command. They are stable from READ through RSP and hold their last values in IDLE.
- Decode table:
  - ADD: alu_src=0, alu_ctrl=000, writes.
  - ADDI: alu_src=1, alu_ctrl=000, writes; rs2_addr is still driven but unused.
  - SUB: alu_src=0, alu_ctrl=001, writes.
  - BNE: alu_src=0, alu_ctrl=001, no write.
- reg_we=1 only in WB, only for a writing op, and only when rd != 0. Writes to x0 are suppressed.
- rsp_taken = BNE and not the registered alu_eq. It is held while rsp_valid is high and forced to 0 for other ops.
- rsp_valid holds until rsp_ready; stalling in RSP has no other side effect.
- retired increments by 1 on each rsp_valid&&rsp_ready edge and wraps from all-ones to 0.
- cmd_* inputs are ignored except at the accept edge.

Decomposition:
- Package alu_seq_pkg holds:
  - op enum: OP_ADD, OP_ADDI, OP_BNE, OP_SUB
  - ALU control constants: ALU_ADD=3'b000, ALU_SUB=3'b001
  - state enum: IDLE, READ, EXEC, WB, RSP
- No sub-module: the decode table is a function in the package, and the FSM plus capture registers live in one module.

Test Plan:
- Reset, then ADDI rd=1 rs1=0 imm=5, rsp_ready=1: alu_src=1, alu_ctrl=000, imm_op=5 during READ..WB; reg_we=1 only in the cycle at accept+3 with rd_addr=1; rsp_valid at accept+4; retired=1.
- BNE rs1=1 rs2=2 with alu_eq=0 in EXEC: reg_we stays 0; rsp_valid with rsp_taken=1. Repeat with alu_eq=1: rsp_taken=0.
- ADD rd=0 rs1=3 rs2=4: reg_we never asserts; response still returned and retired increments.
- Back-to-back: hold cmd_valid with SUB then ADD and rsp_ready=1: second READ directly follows first RSP, giving 4-cycle spacing; rsp_valid pulses exactly once per command.
- Response stall: rsp_ready=0 for 3 cycles in RSP: rsp_valid and rsp_taken held, cmd_ready=0, no extra reg_we. Release: single retire.
- Drop rst_n during WB: reg_we and all outputs go to 0 immediately (async), state returns to IDLE, retired=0. After release, cmd_ready=1 on the next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and decode helper for the ALU sequencing controller.
package alu_seq_pkg;

   // Command opcodes as they arrive on cmd_op.
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_ADDI = 2'b01,
      OP_BNE  = 2'b10,
      OP_SUB  = 2'b11
   } op_e;

   // ALU control encodings understood by the datapath ALU.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   // Controller phases for one command.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      EXEC = 3'd2,
      WB   = 3'd3,
      RSP  = 3'd4
   } state_e;

   // Static datapath controls implied by an opcode.
   typedef struct packed {
      logic       alu_src;   // 1 = immediate feeds ALU operand B
      logic [2:0] alu_ctrl;
      logic       writes;    // op produces a register result
   } ctrl_t;

   // Decode table: opcode to operand select, ALU function and write intent.
   function automatic ctrl_t decode(input op_e op);
      ctrl_t c;
      c = '{alu_src: 1'b0, alu_ctrl: ALU_ADD, writes: 1'b0};
      case (op)
         OP_ADD:  c = '{alu_src: 1'b0, alu_ctrl: ALU_ADD, writes: 1'b1};
         OP_ADDI: c = '{alu_src: 1'b1, alu_ctrl: ALU_ADD, writes: 1'b1};
         OP_SUB:  c = '{alu_src: 1'b0, alu_ctrl: ALU_SUB, writes: 1'b1};
         OP_BNE:  c = '{alu_src: 1'b0, alu_ctrl: ALU_SUB, writes: 1'b0};
         default: c = '{alu_src: 1'b0, alu_ctrl: ALU_ADD, writes: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle controller sequencing regfile read, ALU execute and writeback
// for one command at a time, with a valid/ready command and response pair.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_rs1,
   input  logic [ADDR_WIDTH-1:0] cmd_rs2,
   input  logic [ADDR_WIDTH-1:0] cmd_rd,
   input  logic [DATA_WIDTH-1:0] cmd_imm,
   output logic [ADDR_WIDTH-1:0] rs1_addr,
   output logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  reg_we,
   output logic                  alu_src,
   output logic [2:0]            alu_ctrl,
   output logic [DATA_WIDTH-1:0] imm_op,
   input  logic                  alu_eq,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_taken,
   output logic [CNT_WIDTH-1:0]  retired
);

   state_e                r_state;
   state_e                w_next;
   logic                  r_live;     // first clock after reset release has passed
   op_e                   r_op;
   logic [ADDR_WIDTH-1:0] r_rs1;
   logic [ADDR_WIDTH-1:0] r_rs2;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic [DATA_WIDTH-1:0] r_imm;
   logic                  r_eq;
   logic [CNT_WIDTH-1:0]  r_retired;
   logic                  w_accept;
   logic                  w_retire;
   ctrl_t                 w_ctrl;

   // Handshake qualifiers. cmd_ready stays low while in reset and until the
   // first clock afterwards, so an accept can never race reset release.
   assign cmd_ready = r_live && ((r_state == IDLE) || ((r_state == RSP) && rsp_ready));
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_retire  = (r_state == RSP) && rsp_ready;

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
      end
   end

   // Next-state logic; RSP chains straight into READ on a back-to-back accept.
   // NOTE: w_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = READ;
         READ:    w_next = EXEC;
         EXEC:    w_next = WB;
         WB:      w_next = RSP;
         RSP:     if (rsp_ready) w_next = cmd_valid ? READ : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Command capture on the accept edge; fields hold until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= OP_ADD;
         r_rs1 <= '0;
         r_rs2 <= '0;
         r_rd  <= '0;
         r_imm <= '0;
      end else if (w_accept) begin
         r_op  <= op_e'(cmd_op);
         r_rs1 <= cmd_rs1;
         r_rs2 <= cmd_rs2;
         r_rd  <= cmd_rd;
         r_imm <= cmd_imm;
      end
   end

   // ALU equality flag sampled at the end of EXEC for the branch decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_eq <= 1'b0;
      end else if (r_state == EXEC) begin
         r_eq <= alu_eq;
      end
   end

   // Retired-command counter; wraps naturally at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNT_WIDTH'(1);
      end
   end

   assign w_ctrl = decode(r_op);

   // Datapath controls come straight from the captured command.
   assign rs1_addr  = r_rs1;
   assign rs2_addr  = r_rs2;
   assign rd_addr   = r_rd;
   assign imm_op    = r_imm;
   assign alu_src   = w_ctrl.alu_src;
   assign alu_ctrl  = w_ctrl.alu_ctrl;

   // Writes to x0 are dropped here so the regfile never sees them.
   assign reg_we    = (r_state == WB) && w_ctrl.writes && (r_rd != '0);

   assign rsp_valid = (r_state == RSP);
   assign rsp_taken = (r_state == RSP) && (r_op == OP_BNE) && !r_eq;
   assign retired   = r_retired;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a cycle-age reference model and a
// per-cycle compare of every output.
module tb_alu_seq_ctrl;

   localparam logic [1:0] T_ADD  = 2'b00;
   localparam logic [1:0] T_ADDI = 2'b01;
   localparam logic [1:0] T_BNE  = 2'b10;
   localparam logic [1:0] T_SUB  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
   logic [31:0] cmd_imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        reg_we, alu_src;
   logic [2:0]  alu_ctrl;
   logic [31:0] imm_op;
   logic        alu_eq;
   logic        rsp_valid, rsp_ready, rsp_taken;
   logic [15:0] retired;

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 1'b1;

   alu_seq_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .reg_we(reg_we), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_op(imm_op),
      .alu_eq(alu_eq), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_taken(rsp_taken), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A command is described only by how many clocks have passed since it was
   // accepted: 1 read, 2 execute, 3 writeback, 4+ awaiting response handshake.
   bit          m_live = 0, m_busy = 0, m_eq = 0;
   int          m_age = 0;
   logic [1:0]  m_op = 2'b00;
   logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
   logic [31:0] m_imm = '0;
   logic [15:0] m_retired = '0;

   function automatic bit e_rsp_valid();
      return m_busy && (m_age >= 4);
   endfunction

   function automatic bit e_ready();
      return m_live && (!m_busy || (e_rsp_valid() && rsp_ready));
   endfunction

   function automatic bit e_we();
      return m_busy && (m_age == 3) && (m_op != T_BNE) && (m_rd != 5'd0);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_live = 0; m_busy = 0; m_eq = 0; m_age = 0;
         m_op = 2'b00; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0;
         m_retired = '0;
      end else begin
         bit acc, ret;
         acc = cmd_valid && e_ready();
         ret = e_rsp_valid() && rsp_ready;
         if (m_busy && m_age == 2) m_eq = alu_eq;
         if (ret) begin
            m_retired = m_retired + 16'd1;
            m_busy    = 0;
         end
         if (m_busy && m_age < 4) m_age = m_age + 1;
         if (acc) begin
            m_op = cmd_op; m_rs1 = cmd_rs1; m_rs2 = cmd_rs2;
            m_rd = cmd_rd; m_imm = cmd_imm;
            m_busy = 1; m_age = 1;
         end
         m_live = 1;
      end
   end

   // Per-cycle compare, on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_ready", cmd_ready, e_ready());
         check("rsp_valid", rsp_valid, e_rsp_valid());
         check("reg_we", reg_we, e_we());
         check("rsp_taken", rsp_taken, e_rsp_valid() && m_op == T_BNE && !m_eq);
         check("rs1_addr", rs1_addr, m_rs1);
         check("rs2_addr", rs2_addr, m_rs2);
         check("rd_addr", rd_addr, m_rd);
         check("imm_op", imm_op, m_imm);
         check("alu_src", alu_src, m_op == T_ADDI);
         check("alu_ctrl", alu_ctrl, (m_op == T_SUB || m_op == T_BNE) ? 3'b001 : 3'b000);
         check("retired", retired, m_retired);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] imm);
      cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm = imm;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) break;
         tick();
      end
      check("accept_wait", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom);
      cmd_rd = 5'($urandom); cmd_imm = $urandom;
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) break;
         tick();
      end
      check("rsp_wait", rsp_valid, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0;
      cmd_rd = '0; cmd_imm = '0; alu_eq = 1'b0; rsp_ready = 1'b0;
      repeat (2) tick();
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_retired", retired, 16'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", cmd_ready, 1'b1);

      // ADDI x1 = x0 + 5
      rsp_ready = 1'b1;
      issue(T_ADDI, 5'd0, 5'd0, 5'd1, 32'd5);
      check("addi_read_src", alu_src, 1'b1);
      check("addi_read_imm", imm_op, 32'd5);
      check("addi_read_we", reg_we, 1'b0);
      tick();
      check("addi_exec_we", reg_we, 1'b0);
      tick();
      check("addi_wb_we", reg_we, 1'b1);
      check("addi_wb_rd", rd_addr, 5'd1);
      tick();
      check("addi_rsp_valid", rsp_valid, 1'b1);
      check("addi_rsp_we", reg_we, 1'b0);
      tick();
      check("addi_retired", retired, 16'd1);
      check("addi_rsp_done", rsp_valid, 1'b0);

      // BNE not equal -> taken, then equal -> not taken
      alu_eq = 1'b0;
      issue(T_BNE, 5'd1, 5'd2, 5'd3, 32'd0);
      wait_rsp();
      check("bne_ne_taken", rsp_taken, 1'b1);
      tick();
      alu_eq = 1'b1;
      issue(T_BNE, 5'd1, 5'd2, 5'd3, 32'd0);
      wait_rsp();
      check("bne_eq_taken", rsp_taken, 1'b0);
      tick();
      alu_eq = 1'b0;

      // ADD to x0: no write, still retires
      issue(T_ADD, 5'd3, 5'd4, 5'd0, 32'd0);
      wait_rsp();
      tick();
      check("add_x0_retired", retired, 16'd4);

      // Back-to-back SUB then ADD
      cmd_op = T_SUB; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_rd = 5'd3; cmd_imm = 32'h0;
      cmd_valid = 1'b1;
      tick();
      cmd_op = T_ADD; cmd_rs1 = 5'd5; cmd_rs2 = 5'd6; cmd_rd = 5'd4;
      repeat (3) tick();
      check("b2b_rsp1", rsp_valid, 1'b1);
      check("b2b_ready", cmd_ready, 1'b1);
      check("b2b_ctrl1", alu_ctrl, 3'b001);
      check("b2b_rd1", rd_addr, 5'd3);
      tick();
      cmd_valid = 1'b0;
      check("b2b_gap", rsp_valid, 1'b0);
      check("b2b_ctrl2", alu_ctrl, 3'b000);
      check("b2b_rd2", rd_addr, 5'd4);
      repeat (3) tick();
      check("b2b_rsp2", rsp_valid, 1'b1);
      tick();
      check("b2b_retired", retired, 16'd6);

      // Response stall on a taken branch
      rsp_ready = 1'b0;
      alu_eq = 1'b0;
      issue(T_BNE, 5'd6, 5'd7, 5'd9, 32'd0);
      wait_rsp();
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", rsp_valid, 1'b1);
         check("stall_taken", rsp_taken, 1'b1);
         check("stall_ready", cmd_ready, 1'b0);
         check("stall_retired", retired, 16'd6);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("stall_release", retired, 16'd7);
      check("stall_done", rsp_valid, 1'b0);

      // Reset dropped during writeback
      issue(T_ADD, 5'd1, 5'd2, 5'd5, 32'd0);
      tick();
      tick();
      check("wb_before_rst", reg_we, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_we", reg_we, 1'b0);
      check("rst_ready", cmd_ready, 1'b0);
      check("rst_rd", rd_addr, 5'd0);
      check("rst_ret", retired, 16'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_ready", cmd_ready, 1'b1);
      check("rel_we", reg_we, 1'b0);

      // Recovery command
      issue(T_ADDI, 5'd0, 5'd0, 5'd2, 32'd9);
      wait_rsp();
      tick();
      check("recover_retired", retired, 16'd1);

      repeat (2) tick();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
